// File: rtl/av2_dequant_pkg.sv
// Shared definitions for the AV2 dequantizer: FSM encoding, 8-bit-depth
// quantizer step tables and transform-size helpers.
package av2_dequant_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadQ,
        StStream,
        StFlush,
        StDone
    } state_e;

    // DC quantizer step per qindex, 8-bit depth.
    localparam logic [15:0] DcQlookup [256] = '{
    4, 8, 8, 9, 10, 11, 12, 12, 13, 14, 15, 16, 17, 18, 19, 19,
    20, 21, 22, 23, 24, 25, 26, 26, 27, 28, 29, 30, 31, 32, 32, 33,
    34, 35, 36, 37, 38, 38, 39, 40, 41, 42, 43, 43, 44, 45, 46, 47,
    48, 48, 49, 50, 51, 52, 53, 53, 54, 55, 56, 57, 57, 58, 59, 60,
    61, 62, 62, 63, 64, 65, 66, 66, 67, 68, 69, 70, 70, 71, 72, 73,
    74, 74, 75, 76, 77, 78, 78, 79, 80, 81, 81, 82, 83, 84, 85, 85,
    87, 88, 90, 92, 93, 95, 96, 98, 99, 101, 102, 104, 105, 107, 108, 110,
    111, 113, 114, 116, 117, 118, 120, 121, 123, 125, 127, 129, 131, 134, 136, 138,
    140, 142, 144, 146, 148, 150, 152, 154, 156, 158, 161, 164, 166, 169, 172, 174,
    177, 180, 182, 185, 187, 190, 192, 195, 199, 202, 205, 208, 211, 214, 217, 220,
    223, 226, 230, 233, 237, 240, 243, 247, 250, 253, 257, 261, 265, 269, 272, 276,
    280, 284, 288, 292, 296, 300, 304, 309, 313, 317, 322, 326, 330, 335, 340, 344,
    349, 354, 359, 364, 369, 374, 379, 384, 389, 395, 400, 406, 411, 417, 423, 429,
    435, 441, 447, 454, 461, 467, 475, 482, 489, 497, 505, 513, 522, 530, 539, 549,
    559, 569, 579, 590, 602, 614, 626, 640, 654, 668, 684, 700, 717, 736, 755, 775,
    796, 819, 843, 869, 896, 925, 955, 988, 1022, 1058, 1098, 1139, 1184, 1232, 1282, 1336
    };

    // AC quantizer step per qindex, 8-bit depth.
    localparam logic [15:0] AcQlookup [256] = '{
    4, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 22,
    23, 24, 25, 26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37, 38,
    39, 40, 41, 42, 43, 44, 45, 46, 47, 48, 49, 50, 51, 52, 53, 54,
    55, 56, 57, 58, 59, 60, 61, 62, 63, 64, 65, 66, 67, 68, 69, 70,
    71, 72, 73, 74, 75, 76, 77, 78, 79, 80, 81, 82, 83, 84, 85, 86,
    87, 88, 89, 90, 91, 92, 93, 94, 95, 96, 97, 98, 99, 100, 101, 102,
    104, 106, 108, 110, 112, 114, 116, 118, 120, 122, 124, 126, 128, 130, 132, 134,
    136, 138, 140, 142, 144, 146, 148, 150, 152, 155, 158, 161, 164, 167, 170, 173,
    176, 179, 182, 185, 188, 191, 194, 197, 200, 203, 207, 211, 215, 219, 223, 227,
    231, 235, 239, 243, 247, 251, 255, 260, 265, 270, 275, 280, 285, 290, 295, 300,
    305, 311, 317, 323, 329, 335, 341, 347, 353, 359, 366, 373, 380, 387, 394, 401,
    408, 416, 424, 432, 440, 448, 456, 465, 474, 483, 492, 501, 510, 520, 530, 540,
    550, 560, 571, 582, 593, 604, 615, 627, 639, 651, 663, 676, 689, 702, 715, 729,
    743, 757, 771, 786, 801, 816, 832, 848, 864, 881, 898, 915, 933, 951, 969, 988,
    1007, 1026, 1046, 1066, 1087, 1108, 1129, 1151, 1173, 1196, 1219, 1243, 1267, 1292, 1317, 1343,
    1369, 1396, 1423, 1451, 1479, 1508, 1537, 1567, 1597, 1628, 1660, 1692, 1725, 1759, 1793, 1828
    };

    // tx_size is 6 bits wide, so a 64-point transform arrives as 6'd0.
    function automatic logic [1:0] tx_shift(input logic [5:0] tx);
        case (tx)
            6'd0:    return 2'd2;
            6'd32:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // Coefficients in the block; unsupported sizes behave as 16x16.
    function automatic logic [12:0] tx_area(input logic [5:0] tx);
        case (tx)
            6'd4:    return 13'd16;
            6'd8:    return 13'd64;
            6'd32:   return 13'd1024;
            6'd0:    return 13'd4096;
            default: return 13'd256;
        endcase
    endfunction

endpackage

// File: rtl/av2_dequant_qlut.sv
// Registered quantizer-step ROM: qindex in, DC/AC step out one cycle later.
module av2_dequant_qlut
    import av2_dequant_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  qindex,
    output logic [15:0] dc_q,
    output logic [15:0] ac_q
);

    logic [15:0] dc_d;
    logic [15:0] ac_d;

    // Table lookup.
    always_comb begin
        dc_d = DcQlookup[qindex];
        ac_d = AcQlookup[qindex];
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_q <= '0;
            ac_q <= '0;
        end else begin
            dc_q <= dc_d;
            ac_q <= ac_d;
        end
    end

endmodule

// File: rtl/av2_dequantizer.sv
// Streaming dequantizer: scales each coefficient by the DC/AC step, applies
// the transform-size down-shift and saturates. Optional sticky saturation
// flag enabled by defining AV2_DEQUANT_SAT_FLAG_EN.
module av2_dequantizer
    import av2_dequant_pkg::*;
#(
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned OUT_W   = 20,
    parameter int unsigned ADDR_W  = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         qindex,
    input  logic [5:0]         tx_size,
    input  logic [12:0]        num_coeffs,
    input  logic [COEFF_W-1:0] in_coeff,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [OUT_W-1:0]   out_coeff,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
`ifdef AV2_DEQUANT_SAT_FLAG_EN
    output logic               sat_flag,
`endif
    output logic               done
);

    localparam logic [31:0] NegMag = 32'd1 << (OUT_W - 1);
    localparam logic [31:0] PosMax = NegMag - 32'd1;

    state_e              state_q, state_d;
    logic [7:0]          qindex_q, qindex_d;
    logic [1:0]          shift_q, shift_d;
    logic [12:0]         area_q, area_d;
    logic [12:0]         num_q, num_d;
    logic [12:0]         cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_coeff_q, out_coeff_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                done_q, done_d;

    logic [15:0]         dc_step, ac_step, q_sel;
    logic signed [31:0]  coeff_ext, q_ext, prod;
    logic [31:0]         mag, mag_sh;
    logic                neg, clamp, in_range, hs;
    logic [OUT_W-1:0]    scaled;

    av2_dequant_qlut u_qlut (
        .clk    (clk),
        .rst_n  (rst_n),
        .qindex (qindex_q),
        .dc_q   (dc_step),
        .ac_q   (ac_step)
    );

    assign in_ready  = (state_q == StStream) && (!out_valid_q || out_ready);
    assign hs        = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_coeff = out_coeff_q;
    assign out_addr  = out_addr_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

    // Scale, shift toward zero in magnitude, then clamp to the output range.
    always_comb begin
        q_sel     = (in_addr == '0) ? dc_step : ac_step;
        coeff_ext = {{(32 - COEFF_W){in_coeff[COEFF_W-1]}}, in_coeff};
        q_ext     = {16'd0, q_sel};
        prod      = coeff_ext * q_ext;
        neg       = prod[31];
        mag       = neg ? (32'd0 - prod) : prod;
        mag_sh    = mag >> shift_q;
        clamp     = 1'b0;
        if (!neg && (mag_sh > PosMax)) begin
            clamp  = 1'b1;
            scaled = OUT_W'(PosMax);
        end else if (neg && (mag_sh > NegMag)) begin
            clamp  = 1'b1;
            scaled = OUT_W'(32'd0 - NegMag);
        end else begin
            scaled = neg ? OUT_W'(32'd0 - mag_sh) : OUT_W'(mag_sh);
        end
        in_range = 32'(in_addr) < 32'(area_q);
    end

    // Block framing FSM.
    always_comb begin
        state_d  = state_q;
        qindex_d = qindex_q;
        shift_d  = shift_q;
        area_d   = area_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        done_d   = (state_q == StDone);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    qindex_d = qindex;
                    shift_d  = tx_shift(tx_size);
                    area_d   = tx_area(tx_size);
                    num_d    = num_coeffs;
                    cnt_d    = '0;
                    state_d  = (num_coeffs == '0) ? StDone : StLoadQ;
                end
            end
            StLoadQ: state_d = StStream;
            StStream: begin
                if (hs) begin
                    cnt_d = cnt_q + 13'd1;
                    if (cnt_q + 13'd1 == num_q) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (!out_valid_q || out_ready) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Single output stage; out-of-range addresses are consumed silently.
    always_comb begin
        out_valid_d = out_valid_q;
        out_coeff_d = out_coeff_q;
        out_addr_d  = out_addr_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (hs && in_range) begin
            out_valid_d = 1'b1;
            out_coeff_d = scaled;
            out_addr_d  = in_addr;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            qindex_q    <= '0;
            shift_q     <= '0;
            area_q      <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_coeff_q <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            qindex_q    <= qindex_d;
            shift_q     <= shift_d;
            area_q      <= area_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_coeff_q <= out_coeff_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
        end
    end

`ifdef AV2_DEQUANT_SAT_FLAG_EN
    logic sat_flag_q, sat_flag_d;

    // Sticky flag: cleared by an accepted start, set by any clamp.
    always_comb begin
        sat_flag_d = sat_flag_q;
        if ((state_q == StIdle) && start) begin
            sat_flag_d = 1'b0;
        end else if (hs && clamp) begin
            sat_flag_d = 1'b1;
        end
    end

    // Flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag_q <= 1'b0;
        end else begin
            sat_flag_q <= sat_flag_d;
        end
    end

    assign sat_flag = sat_flag_q;
`else
    logic unused_clamp;
    assign unused_clamp = clamp;
`endif

endmodule

// File: tb/tb_av2_dequantizer.sv
// Self-checking bench for av2_dequantizer with a scoreboard of expected outputs.
module tb_av2_dequantizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  qindex;
    logic [5:0]  tx_size;
    logic [12:0] num_coeffs;
    logic [15:0] in_coeff;
    logic [11:0] in_addr;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] out_coeff;
    logic [11:0] out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef AV2_DEQUANT_SAT_FLAG_EN
    logic        sat_flag;
`endif

    always #5 clk = ~clk;

    av2_dequantizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .qindex     (qindex),
        .tx_size    (tx_size),
        .num_coeffs (num_coeffs),
        .in_coeff   (in_coeff),
        .in_addr    (in_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_coeff  (out_coeff),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
`ifdef AV2_DEQUANT_SAT_FLAG_EN
        .sat_flag   (sat_flag),
`endif
        .done       (done)
    );

    typedef struct {
        int coeff;
        int addr;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   done_cnt = 0;
    bit   acc;
    bit   stall_chk = 1'b0;
    logic last_done, last_busy, last_in_ready;
    int   lat;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sampled at the falling edge, where everything is stable.
    task automatic monitor();
        exp_t e;
        acc           = in_valid && in_ready;
        last_done     = done;
        last_busy     = busy;
        last_in_ready = in_ready;
        if (done === 1'b1) done_cnt++;
        if (stall_chk) begin
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_out_coeff", $signed(out_coeff), sb[0].coeff);
            chk("stall_out_addr", 32'(out_addr), sb[0].addr);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("out_coeff", $signed(out_coeff), e.coeff);
                chk("out_addr", 32'(out_addr), e.addr);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic start_blk(input int q, input int tx, input int num);
        qindex     = 8'(q);
        tx_size    = 6'(tx);
        num_coeffs = 13'(num);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic send(input int addr, input int coeff, input bit fwd, input int expv,
                        output int n);
        bit got = 1'b0;
        if (fwd) sb.push_back(exp_t'{coeff: expv, addr: addr});
        in_addr  = 12'(addr);
        in_coeff = 16'(coeff);
        in_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            n++;
            got = acc;
        end
        chk("input_accepted", 32'(got), 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_total);
        for (int i = 0; i < 20 && done_cnt < exp_total; i++) tick();
        chk("done_count", done_cnt, exp_total);
        tick();
        tick();
        chk("done_single_pulse", done_cnt, exp_total);
        chk("scoreboard_drained", sb.size(), 0);
        chk("idle_after_done", 32'(last_busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; qindex = '0; tx_size = '0; num_coeffs = '0;
        in_coeff = '0; in_addr = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_coeff", 32'(out_coeff), 0);
        chk("rst_out_addr", 32'(out_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
`ifdef AV2_DEQUANT_SAT_FLAG_EN
        chk("rst_sat_flag", 32'(sat_flag), 0);
`endif
        rst_n = 1'b1;
        tick();

        // qindex 0 (dc 4, ac 4), tx 4, two coefficients.
        start_blk(0, 4, 2);
        tick();
        chk("loadq_in_ready", 32'(last_in_ready), 0);
        chk("loadq_busy", 32'(last_busy), 1);
        send(0, 3, 1'b1, 12, lat);
        chk("first_accept_cycle2", lat, 1);
        send(1, -5, 1'b1, -20, lat);
        chk("back_to_back_accept", lat, 1);
        wait_done(1);

        // qindex 2 (ac 9), tx 64: -9 >> 2 truncates toward zero.
        start_blk(2, 64, 1);
        send(1, -1, 1'b1, -2, lat);
        wait_done(2);

        // qindex 255 (ac 1828), tx 16: both ends saturate.
        start_blk(255, 16, 2);
        send(1, 32767, 1'b1, 524287, lat);
        send(1, -32768, 1'b1, -524288, lat);
        wait_done(3);
`ifdef AV2_DEQUANT_SAT_FLAG_EN
        chk("sat_flag_set", 32'(sat_flag), 1);
`endif

        // tx 8: address 70 is beyond 64 and is dropped.
        start_blk(0, 8, 3);
`ifdef AV2_DEQUANT_SAT_FLAG_EN
        chk("sat_flag_cleared", 32'(sat_flag), 0);
`endif
        send(0, 1, 1'b1, 4, lat);
        send(70, 2, 1'b0, 0, lat);
        send(5, 3, 1'b1, 12, lat);
        wait_done(4);

        // Back-pressure for five cycles mid-stream.
        start_blk(0, 16, 6);
        send(1, 10, 1'b1, 40, lat);
        send(2, -7, 1'b1, -28, lat);
        send(3, 100, 1'b1, 400, lat);
        out_ready = 1'b0;
        in_addr   = 12'd4;
        in_coeff  = 16'd55;
        in_valid  = 1'b1;
        stall_chk = 1'b1;
        repeat (5) tick();
        stall_chk = 1'b0;
        out_ready = 1'b1;
        send(4, 55, 1'b1, 220, lat);
        send(5, -1, 1'b1, -4, lat);
        send(6, 2, 1'b1, 8, lat);
        wait_done(5);

        // Empty block: done two cycles after start.
        start_blk(0, 16, 0);
        tick();
        chk("num0_done_cycle1", 32'(last_done), 0);
        tick();
        chk("num0_done_cycle2", 32'(last_done), 1);
        chk("num0_done_count", done_cnt, 6);
        tick();

        // Reset while a result is held in the output stage.
        start_blk(0, 16, 4);
        out_ready = 1'b0;
        send(1, 5, 1'b0, 0, lat);
        tick();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_coeff", 32'(out_coeff), 0);
        chk("mid_rst_out_addr", 32'(out_addr), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
`ifdef AV2_DEQUANT_SAT_FLAG_EN
        chk("mid_rst_sat_flag", 32'(sat_flag), 0);
`endif
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("no_partial_done", done_cnt, 6);
        chk("idle_after_reset", 32'(last_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
